// File: rtl/hazard_scoreboard.sv
// Per-register ready countdowns with configurable producer latencies and branch penalty.
// Drives stall/flush/issue for the ID stage and counts stall and flush cycles.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int CW         = 3,
    parameter int ALU_LAT    = 0,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [AW-1:0]   id_rs1_i,
    input  logic [AW-1:0]   id_rs2_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic [AW-1:0]   id_rd_i,
    input  logic            id_regwrite_i,
    input  logic            id_memread_i,
    input  logic            branch_taken_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic            issue_o,
    output logic [NREG-1:0] pending_o,
    output logic [31:0]     stall_cycles_o,
    output logic [31:0]     flush_cycles_o
);

    localparam logic [CW-1:0] ALU_CNT    = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_CNT   = CW'(LOAD_LAT);
    localparam logic [CW-1:0] FLUSH_INIT = (BR_PENALTY > 1) ? CW'(BR_PENALTY - 2) : '0;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] fcnt;
    logic [CW-1:0] cnt [NREG];
    logic          hit1, hit2, kill, br;

    always_comb begin
        kill    = (state == FLUSH);
        hit1    = id_use_rs1_i && (id_rs1_i != '0) && (cnt[id_rs1_i] != '0);
        hit2    = id_use_rs2_i && (id_rs2_i != '0) && (cnt[id_rs2_i] != '0);
        stall_o = ~rst_i & id_valid_i & ~kill & (hit1 | hit2);
        issue_o = ~rst_i & id_valid_i & ~kill & ~(hit1 | hit2);
        br      = issue_o & branch_taken_i;
        flush_o = ~rst_i & (br | kill);
        pending_o = '0;
        for (int r = 1; r < NREG; r++) begin
            pending_o[r] = ~rst_i & (cnt[r] != '0);
        end
    end

    // A newly issued producer reloads its rd countdown, overriding the decrement (youngest wins).
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst_i || r == 0) begin
                cnt[r] <= '0;
            end else if (issue_o && id_regwrite_i && id_rd_i == AW'(r)) begin
                cnt[r] <= id_memread_i ? LOAD_CNT : ALU_CNT;
            end else if (cnt[r] != '0) begin
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // The branch's own issue cycle is the first flush cycle, so FLUSH covers BR_PENALTY-1 more.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (br && BR_PENALTY > 1) begin
                        state <= FLUSH;
                        fcnt  <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state <= RUN;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles_o <= '0;
            flush_cycles_o <= '0;
        end else begin
            stall_cycles_o <= stall_cycles_o + {31'd0, stall_o};
            flush_cycles_o <= flush_cycles_o + {31'd0, flush_o};
        end
    end

endmodule
